keypad_encoder: RTL
===================

Name: keypad_encoder

Overview:
- Scans a 4x4 matrix hex keypad, debounces it and encodes the pressed key into a 4-bit code.
- This is the input end of the hex display path: KeyCode drives the 4-bit input of the seven-segment decoder directly.
- Emits a one-cycle KeyValid strobe per debounced press and a level KeyHeld while the key stays down.

Parameters:
- SCAN_DIV, 50000: Clk cycles per column slot (one "tick" at the end of each slot). Minimum 2.
- DEBOUNCE_SCANS, 4: consecutive agreeing ticks required to accept a press or a release. Minimum 1.
- REPEAT_DELAY, 250: ticks before auto-repeat starts. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 50: ticks between repeat strobes. Used only with KEYPAD_REPEAT_EN.

Ports:
- Clk, input, 1: system clock; all logic on rising edge.
- Rst, input, 1: asynchronous, active-low reset.
- Rows, input, 4: keypad row lines; active-low, externally pulled up; asynchronous to Clk.
- Cols, output, 4: column drive; active-low one-hot.
- KeyCode, output, 4: code of the last accepted key; holds between presses.
- KeyValid, output, 1: one-Clk pulse when a press is accepted.
- KeyHeld, output, 1: high from acceptance until the release is accepted.

Behaviour:
- Reset values (async, Rst=0):
  - Cols=4'b1110, KeyCode=4'h0, KeyValid=0, KeyHeld=0.
  - State=SCAN; divider, column index and debounce counter = 0; synchronizer flops = 4'b1111.
- Rows input path:
  - Rows passes through a 2-flop synchronizer.
  - The synchronized value is sampled only on a tick, i.e. the last cycle of a column slot.
- Column drive: Cols = ~(1<<col). The column index advances on a tick only in SCAN, wrapping 3->0.
- Key map, (row,col):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *=E, 0=0, #=F, D=D
- FSM, evaluated on ticks only:
  - SCAN: if exactly one row is low, latch the candidate row and column, set count=1, freeze the column, go to DEBOUNCE. If zero or more than one row is low, stay in SCAN and advance the column.
  - DEBOUNCE: if the same single row is low, count++. When count reaches DEBOUNCE_SCANS, go to PRESSED. Any other sample goes to SCAN with count cleared, and the column resumes advancing.
  - PRESSED: column stays frozen. Each all-high sample increments the release count; any low row clears it. When the release count reaches DEBOUNCE_SCANS, go to SCAN.
- Entry into PRESSED (Clk cycle after the accepting tick):
  - KeyCode is updated from the map.
  - KeyValid is high for exactly 1 Clk.
  - KeyHeld goes to 1.
- Leaving PRESSED: KeyHeld goes to 0 in the Clk cycle after the accepting release tick. KeyCode is retained.
- With DEBOUNCE_SCANS=1, a key is accepted on the first qualifying tick.
- Latency: press sampled at tick T0 → KeyValid at tick T0+(DEBOUNCE_SCANS-1) slots, plus 1 Clk.
- Press ignore rules:
  - A second key pressed in PRESSED is ignored; no new strobe.
  - A multi-row press in the frozen column counts as "not released".
- Reset mid-operation returns to the reset state immediately. A key still held afterwards is re-detected and produces a fresh strobe after a full debounce.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a tick counter starts at acceptance.
  - After REPEAT_DELAY ticks, KeyValid pulses for 1 Clk, then again every REPEAT_RATE ticks while the key is held. KeyCode is unchanged.
  - The counter clears on leaving PRESSED or on reset.
- Macro undefined: exactly one KeyValid per press; the repeat counter logic is absent.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 unless stated.
- Reset, no keys: during reset, Cols=1110 and all outputs 0. After reset, Cols cycles 1110→1101→1011→0111→1110, 4 Clk per step, and KeyValid never asserts.
- Hold key '5' (Rows[1] low whenever Cols[1]=0) for 40 Clk, then release:
  - Exactly one KeyValid pulse, KeyCode=4'h5.
  - KeyHeld=1 until 3 all-high ticks after release.
  - Cols frozen at 1101 throughout.
- Bounce on key '9': valid for 2 ticks, then high for 1 tick → no KeyValid, scan resumes. A later clean hold gives one pulse with KeyCode=4'h9.
- Keys '2' and '5' held together (Rows[0] and Rows[1] low on col1) → no KeyValid, scan continues.
  - Sequentially pressing '*', '#', 'D' gives KeyCode E, F, D respectively, each with one pulse.
- Reset asserted while in PRESSED on 'A' → outputs immediately at reset values. With 'A' still held after reset, KeyValid pulses again with KeyCode=4'hA after 3 ticks.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=5, REPEAT_RATE=2, holding '7' → KeyValid pulses at acceptance and at +5, +7, +9 ticks until release, KeyCode=4'h7 throughout.

Source files
------------

// File: rtl/keypad_encoder_if.sv
// keypad_encoder_if: keypad-side bundle of the hex keypad encoder.
// master = keypad/consumer side, slave = encoder.
interface keypad_encoder_if;
  logic [3:0] Rows;
  logic [3:0] Cols;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyHeld;

  modport master (
    output Rows,
    input  Cols,
    input  KeyCode,
    input  KeyValid,
    input  KeyHeld
  );

  modport slave (
    input  Rows,
    output Cols,
    output KeyCode,
    output KeyValid,
    output KeyHeld
  );
endinterface

// File: rtl/keypad_encoder.sv
// keypad_encoder: 4x4 hex keypad scanner, debouncer and encoder.
// Optional auto-repeat strobes when built with KEYPAD_REPEAT_EN.
module keypad_encoder #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 250,
  parameter int unsigned REPEAT_RATE    = 50
`endif
) (
  input  logic Clk,
  input  logic Rst,
  keypad_encoder_if.slave kp
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_t;

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_row;
  logic [3:0]       r_code;
  logic             r_valid;
  logic             r_held;

  logic             w_tick;
  logic [3:0]       w_low;
  logic             w_single;
  logic [1:0]       w_idx;
  logic             w_all_high;
  logic             w_release;
  logic             w_rep_fire;

  // Row/column position to hex code.
  function automatic logic [3:0] f_map(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign w_tick     = (r_div == DIV_LAST);
  assign w_low      = ~r_sync2;
  assign w_single   = (w_low != 4'd0) &&
                      ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_all_high = &r_sync2;
  assign w_release  = w_all_high && (r_cnt == DB_LAST);

  // Index of the single low row (meaningful only with w_single).
  always_comb begin
    w_idx = 2'd0;
    case (w_low)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // Bring the asynchronous row lines into the Clk domain.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= kp.Rows;
      r_sync2 <= r_sync1;
    end
  end

  // Column slot divider; tick on the last cycle of each slot.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RT  = REP_W'(REPEAT_RATE);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [REP_W-1:0] r_rep;

  assign w_rep_fire = (r_state == PRESSED) && w_tick &&
                      !w_release && (r_rep == REP_ONE);

  // Ticks remaining until the next repeat strobe while held.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rep <= '0;
    end else if (r_state != PRESSED) begin
      r_rep <= REP_DLY;
    end else if (w_tick && !w_release) begin
      r_rep <= (r_rep == REP_ONE) ? REP_RT : r_rep - 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Scan/debounce/hold state machine, stepped on ticks.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= SCAN;
      r_col   <= 2'd0;
      r_cnt   <= '0;
      r_row   <= 2'd0;
      r_code  <= 4'h0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_valid <= w_rep_fire;
      if (w_tick) begin
        unique case (r_state)
          SCAN: begin
            if (w_single) begin
              r_row <= w_idx;
              if (DEBOUNCE_SCANS == 1) begin
                r_state <= PRESSED;
                r_code  <= f_map(w_idx, r_col);
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_state <= DEBOUNCE;
                r_cnt   <= CNT_ONE;
              end
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (w_single && (w_idx == r_row)) begin
              if (r_cnt == DB_LAST) begin
                r_state <= PRESSED;
                r_code  <= f_map(r_row, r_col);
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_state <= SCAN;
              r_cnt   <= '0;
            end
          end
          PRESSED: begin
            if (w_all_high) begin
              if (r_cnt == DB_LAST) begin
                r_state <= SCAN;
                r_held  <= 1'b0;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          default: begin
            r_state <= SCAN;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign kp.Cols     = ~(4'b0001 << r_col);
  assign kp.KeyCode  = r_code;
  assign kp.KeyValid = r_valid;
  assign kp.KeyHeld  = r_held;

endmodule
